// File: rtl/d_mem_responder_pkg.sv
// d_mem_responder shared definitions.
// State encoding, latency counter width and legal latency range.
package d_mem_responder_pkg;

    localparam int LAT_BITS = 4;
    localparam int LAT_MIN  = 1;
    localparam int LAT_MAX  = 15;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/d_mem_array.sv
// d_mem_array: single-port synchronous RAM.
// Registered read; contents are never reset.
module d_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_BITS = 10
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_BITS-1:0] index,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_BITS)-1];

    // Write or read the addressed word on an enabled edge.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[index] <= wdata;
            end else begin
                rdata <= mem[index];
            end
        end
    end

endmodule

// File: rtl/d_mem_responder.sv
// d_mem_responder: data-memory responder with fixed response latency.
// One request in flight; reads return a one-cycle valid pulse.
module d_mem_responder
    import d_mem_responder_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int DEPTH_BITS   = 10,
    parameter int LATENCY      = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDRESS_BITS-1:0] address,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    ready,
    output logic                    valid,
    output logic [ADDRESS_BITS-1:0] out_addr,
    output logic [DATA_WIDTH-1:0]   out_data,
    input  logic                    report
);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("d_mem_responder: LATENCY must be in 1..15");
    end

    localparam logic [LAT_BITS-1:0] LAT_INIT = LAT_BITS'(LATENCY - 1);

    state_t                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;
    logic [LAT_BITS-1:0]     cnt_q, cnt_d;
    logic                    is_write_q, is_write_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [ADDRESS_BITS-1:0] out_addr_q, out_addr_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    accept;
    logic                    unused_tieoff;

    // The report port is kept for interface compatibility only.
    assign unused_tieoff = report & (CORE >= 0);

    assign accept = ready_q & (read | write);

    d_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_array (
        .clock (clock),
        .en    (accept),
        .we    (accept & write),
        .index (address[DEPTH_BITS-1:0]),
        .wdata (in_data),
        .rdata (rdata)
    );

    // State, counter and response registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end

    // Accept in IDLE, count down in WAIT, respond on completion.
    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        valid_d    = 1'b0;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    state_d    = WAIT;
                    ready_d    = 1'b0;
                    cnt_d      = LAT_INIT;
                    is_write_d = write;
                    addr_d     = address;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    if (!is_write_q) begin
                        valid_d    = 1'b1;
                        out_data_d = rdata;
                        out_addr_d = addr_q;
                    end
                end else begin
                    cnt_d = cnt_q - LAT_BITS'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready    = ready_q;
    assign valid    = valid_q;
    assign out_addr = out_addr_q;
    assign out_data = out_data_q;

endmodule

// File: tb/tb_d_mem_responder.sv
// tb_d_mem_responder: directed checks of d_mem_responder.
// Instances at LATENCY 2, 1 and 4 share clock and reset.
module tb_d_mem_responder;

    logic        clock;
    logic        reset;
    logic        rd  [3];
    logic        wr  [3];
    logic [19:0] ad  [3];
    logic [31:0] wd  [3];
    logic        rdy [3];
    logic        vld [3];
    logic [19:0] oa  [3];
    logic [31:0] od  [3];

    int checks;
    int errors;
    int cyc;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        d_mem_responder #(
            .CORE         (i),
            .DATA_WIDTH   (32),
            .ADDRESS_BITS (20),
            .DEPTH_BITS   (10),
            .LATENCY      ((i == 0) ? 2 : ((i == 1) ? 1 : 4))
        ) u_dut (
            .clock    (clock),
            .reset    (reset),
            .read     (rd[i]),
            .write    (wr[i]),
            .address  (ad[i]),
            .in_data  (wd[i]),
            .ready    (rdy[i]),
            .valid    (vld[i]),
            .out_addr (oa[i]),
            .out_data (od[i]),
            .report   (1'b0)
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one request once ready, then observe until ready returns.
    task automatic issue(
        input  int          d,
        input  logic        r,
        input  logic        w,
        input  logic [19:0] a,
        input  logic [31:0] dat,
        input  bit          hold,
        output bit          acc0,
        output int          rdy_n,
        output int          vcnt,
        output int          vn,
        output logic [31:0] vd,
        output logic [19:0] va
    );
        int g;
        g = 0;
        while (rdy[d] !== 1'b1 && g < 50) begin
            tick();
            g++;
        end
        rd[d] = r;
        wr[d] = w;
        ad[d] = a;
        wd[d] = dat;
        tick();
        acc0 = (rdy[d] === 1'b0) && (vld[d] === 1'b0);
        if (!hold) begin
            rd[d] = 1'b0;
            wr[d] = 1'b0;
        end
        rdy_n = -1;
        vcnt  = 0;
        vn    = -1;
        vd    = '0;
        va    = '0;
        for (int n = 1; n <= 20 && rdy_n < 0; n++) begin
            tick();
            if (vld[d] === 1'b1) begin
                vcnt++;
                if (vn < 0) begin
                    vn = n;
                    vd = od[d];
                    va = oa[d];
                end
            end
            if (rdy[d] === 1'b1) rdy_n = n;
        end
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd[i] = 1'b0;
            wr[i] = 1'b0;
            ad[i] = '0;
            wd[i] = '0;
        end
        tick();
        tick();
        checks++;
        if (rdy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b want 0", rdy[0]);
        end
        checks++;
        if (vld[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", vld[0]);
        end
        checks++;
        if (od[0] !== 32'h0 || oa[0] !== 20'h0) begin
            errors++;
            $display("FAIL reset_out got %h/%h want 0/0", od[0], oa[0]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (rdy[0] !== 1'b0) begin
            errors++;
            $display("FAIL release_ready_early got %b want 0", rdy[0]);
        end
        tick();
        checks++;
        if (rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL release_ready got %b want 1", rdy[0]);
        end
    endtask

    task automatic test_write_read();
        bit          acc0;
        int          rn, vc, vn;
        logic [31:0] vd;
        logic [19:0] va;
        issue(0, 1'b0, 1'b1, 20'h00010, 32'hDEADBEEF, 1'b0,
              acc0, rn, vc, vn, vd, va);
        checks++;
        if (!acc0 || rn !== 2 || vc !== 0) begin
            errors++;
            $display("FAIL write_timing got acc=%0b rdy_n=%0d vcnt=%0d want 1/2/0",
                     acc0, rn, vc);
        end
        issue(0, 1'b1, 1'b0, 20'h00010, 32'h0, 1'b0,
              acc0, rn, vc, vn, vd, va);
        checks++;
        if (!acc0 || rn !== 2 || vn !== 2 || vc !== 1) begin
            errors++;
            $display("FAIL read_timing got acc=%0b rdy_n=%0d vn=%0d vcnt=%0d want 1/2/2/1",
                     acc0, rn, vn, vc);
        end
        checks++;
        if (vd !== 32'hDEADBEEF || va !== 20'h00010) begin
            errors++;
            $display("FAIL read_data got %h@%h want deadbeef@00010", vd, va);
        end
        tick();
        checks++;
        if (vld[0] !== 1'b0 || od[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_pulse_end got v=%b d=%h want 0/deadbeef",
                     vld[0], od[0]);
        end
    endtask

    task automatic test_simultaneous_hold();
        bit          acc0;
        int          rn, vc, vn;
        logic [31:0] vd;
        logic [19:0] va;
        issue(0, 1'b1, 1'b1, 20'h00003, 32'h12345678, 1'b0,
              acc0, rn, vc, vn, vd, va);
        checks++;
        if (rn !== 2 || vc !== 0) begin
            errors++;
            $display("FAIL rw_no_valid got rdy_n=%0d vcnt=%0d want 2/0", rn, vc);
        end
        checks++;
        if (od[0] !== 32'hDEADBEEF || oa[0] !== 20'h00010) begin
            errors++;
            $display("FAIL rw_out_hold got %h@%h want deadbeef@00010", od[0], oa[0]);
        end
        issue(0, 1'b1, 1'b0, 20'h00003, 32'h0, 1'b1,
              acc0, rn, vc, vn, vd, va);
        checks++;
        if (rn !== 2 || vc !== 1 || vd !== 32'h12345678 || va !== 20'h00003) begin
            errors++;
            $display("FAIL hold_read got rdy_n=%0d vcnt=%0d %h@%h want 2/1 12345678@00003",
                     rn, vc, vd, va);
        end
        tick();
        checks++;
        if (rdy[0] !== 1'b1 || vld[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold_once got rdy=%b v=%b want 1/0", rdy[0], vld[0]);
        end
    endtask

    task automatic test_alias();
        bit          acc0;
        int          rn, vc, vn;
        logic [31:0] vd;
        logic [19:0] va;
        issue(0, 1'b0, 1'b1, 20'h00405, 32'hA5A5A5A5, 1'b0,
              acc0, rn, vc, vn, vd, va);
        issue(0, 1'b1, 1'b0, 20'h00005, 32'h0, 1'b0,
              acc0, rn, vc, vn, vd, va);
        checks++;
        if (vc !== 1 || vd !== 32'hA5A5A5A5 || va !== 20'h00005) begin
            errors++;
            $display("FAIL alias_read got vcnt=%0d %h@%h want 1 a5a5a5a5@00005",
                     vc, vd, va);
        end
        issue(0, 1'b1, 1'b0, 20'hFFC05, 32'h0, 1'b0,
              acc0, rn, vc, vn, vd, va);
        checks++;
        if (vd !== 32'hA5A5A5A5 || va !== 20'hFFC05) begin
            errors++;
            $display("FAIL alias_full_addr got %h@%h want a5a5a5a5@ffc05", vd, va);
        end
    endtask

    task automatic test_back_to_back();
        bit          acc0;
        int          rn, vc, vn;
        logic [31:0] vd;
        logic [19:0] va;
        int          vcyc [4];
        logic [31:0] exp;
        for (int i = 1; i <= 4; i++) begin
            exp = 32'h11 * i;
            issue(1, 1'b0, 1'b1, 20'(i), exp, 1'b0,
                  acc0, rn, vc, vn, vd, va);
        end
        for (int i = 1; i <= 4; i++) begin
            exp = 32'h11 * i;
            issue(1, 1'b1, 1'b0, 20'(i), 32'h0, 1'b0,
                  acc0, rn, vc, vn, vd, va);
            vcyc[i-1] = cyc;
            checks++;
            if (!acc0 || rn !== 1 || vn !== 1 || vd !== exp || va !== 20'(i)) begin
                errors++;
                $display("FAIL b2b_read%0d got acc=%0b rdy_n=%0d vn=%0d %h@%h want 1/1/1 %h@%h",
                         i, acc0, rn, vn, vd, va, exp, 20'(i));
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (vcyc[i] - vcyc[i-1] !== 2) begin
                errors++;
                $display("FAIL b2b_spacing%0d got %0d want 2", i, vcyc[i] - vcyc[i-1]);
            end
        end
        tick();
        tick();
        checks++;
        if (vld[1] !== 1'b0 || od[1] !== 32'h44 || oa[1] !== 20'h4) begin
            errors++;
            $display("FAIL b2b_stable got v=%b %h@%h want 0 00000044@00004",
                     vld[1], od[1], oa[1]);
        end
    endtask

    task automatic test_reset_mid_read();
        bit          acc0;
        int          rn, vc, vn;
        int          seen;
        logic [31:0] vd;
        logic [19:0] va;
        issue(2, 1'b0, 1'b1, 20'h00007, 32'h00000077, 1'b0,
              acc0, rn, vc, vn, vd, va);
        checks++;
        if (rn !== 4 || vc !== 0) begin
            errors++;
            $display("FAIL lat4_write got rdy_n=%0d vcnt=%0d want 4/0", rn, vc);
        end
        rd[2] = 1'b1;
        ad[2] = 20'h00007;
        tick();
        rd[2] = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (rdy[2] !== 1'b0 || vld[2] !== 1'b0 || od[2] !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_out got rdy=%b v=%b d=%h want 0/0/0",
                     rdy[2], vld[2], od[2]);
        end
        tick();
        reset = 1'b1;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (vld[2] === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || rdy[2] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_drop got pulses=%0d rdy=%b want 0/1", seen, rdy[2]);
        end
        issue(2, 1'b1, 1'b0, 20'h00007, 32'h0, 1'b0,
              acc0, rn, vc, vn, vd, va);
        checks++;
        if (rn !== 4 || vn !== 4 || vc !== 1 || vd !== 32'h77 || va !== 20'h7) begin
            errors++;
            $display("FAIL post_reset_read got rdy_n=%0d vn=%0d vcnt=%0d %h@%h want 4/4/1 00000077@00007",
                     rn, vn, vc, vd, va);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        test_reset();
        test_write_read();
        test_simultaneous_hold();
        test_alias();
        test_back_to_back();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
